// File: rtl/iter_div_unit_if.sv
// Operand/result handshake bundle between the execute stage and the iterative divider.
// slave = divider side, master = pipeline side.
interface iter_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       funct;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Out;

    modport slave (
        input  in_valid, A, B, funct, out_ready,
        output in_ready, out_valid, Out
    );

    modport master (
        output in_valid, A, B, funct, out_ready,
        input  in_ready, out_valid, Out
    );
endinterface

// File: rtl/iter_div_unit.sv
// RV32M DIV/DIVU/REM/REMU, restoring radix-2: WIDTH CALC cycles, 1 cycle for /0 and overflow.
// Accepts only in IDLE; result held in DONE until out_ready. Optional ITER_DIV_FLUSH_EN adds i_flush.
module iter_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic i_clk,
    input  logic i_rst,
`ifdef ITER_DIV_FLUSH_EN
    input  logic i_flush,
`endif
    iter_div_unit_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem, r_quo, r_div, r_out;
    logic             r_is_rem, r_q_neg, r_r_neg;

    logic             w_flush;
    logic             w_signed, w_is_rem, w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_a_mag, w_b_mag, w_special_res;
    logic             w_b_zero, w_ovf, w_special, w_accept;
    logic [WIDTH:0]   w_shift, w_diff;
    logic [WIDTH-1:0] w_rem_nxt, w_quo_nxt, w_calc_res;
    logic             w_last;

`ifdef ITER_DIV_FLUSH_EN
    assign w_flush = i_flush;
`else
    assign w_flush = 1'b0;
`endif

    // funct[0]=1 selects unsigned, funct[1]=1 selects remainder
    assign w_signed = ~bus.funct[0];
    assign w_is_rem = bus.funct[1];
    assign w_a_neg  = w_signed & bus.A[WIDTH-1];
    assign w_b_neg  = w_signed & bus.B[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -bus.A : bus.A;
    assign w_b_mag  = w_b_neg ? -bus.B : bus.B;

    assign w_b_zero  = (bus.B == '0);
    assign w_ovf     = w_signed & (bus.A == {1'b1, {(WIDTH-1){1'b0}}}) & (&bus.B);
    assign w_special = w_b_zero | w_ovf;
    assign w_special_res = w_is_rem ? (w_b_zero ? bus.A : '0)
                                    : (w_b_zero ? '1    : bus.A);

    // funct[2] marks an M-extension divide op; other encodings are never issued
    assign w_accept = (r_state == S_IDLE) & bus.in_valid & bus.funct[2] & ~w_flush;

    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_diff    = w_shift - {1'b0, r_div};
    assign w_rem_nxt = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
    assign w_last    = (r_cnt == CNT_W'(WIDTH-1));

    assign w_calc_res = r_is_rem ? (r_r_neg ? -w_rem_nxt : w_rem_nxt)
                                 : (r_q_neg ? -w_quo_nxt : w_quo_nxt);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept)      w_state_nxt = w_special ? S_DONE : S_CALC;
            S_CALC: if (w_last)        w_state_nxt = S_DONE;
            S_DONE: if (bus.out_ready) w_state_nxt = S_IDLE;
            default:                   w_state_nxt = S_IDLE;
        endcase
        if (w_flush) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_out    <= '0;
            r_is_rem <= 1'b0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= w_a_mag;
            r_div    <= w_b_mag;
            r_is_rem <= w_is_rem;
            r_q_neg  <= (w_a_neg ^ w_b_neg) & ~w_b_zero;
            r_r_neg  <= w_a_neg;
            if (w_special) r_out <= w_special_res;
        end else if (r_state == S_CALC && !w_flush) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) r_out <= w_calc_res;
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.Out       = r_out;

endmodule

// File: tb/tb_iter_div_unit.sv
// Randomized and directed check of iter_div_unit against an arithmetic RV32M reference.
module tb_iter_div_unit;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    logic flush = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   excl_err = 0;
    logic [31:0] last_out = '0;

    always #5 i_clk = ~i_clk;

    iter_div_unit_if #(.WIDTH(32)) bus ();

    iter_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
`ifdef ITER_DIV_FLUSH_EN
        .i_flush (flush),
`endif
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        int sa = a;
        int sb = b;
        case (f)
            3'b100: if (b == 0) return 32'hFFFF_FFFF;
                    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                    else return sa / sb;
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: if (b == 0) return a;
                    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
                    else return sa % sb;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        return (b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    always @(negedge i_clk) if (bus.in_ready && bus.out_valid) excl_err++;

    // Caller is #1 after a rising edge with the unit idle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f, input int hold);
        logic [31:0] exp;
        int exp_lat;
        int lat;
        exp     = model(a, b, f);
        exp_lat = is_special(a, b, f) ? 0 : 32;
        chk("idle_ready", bus.in_ready, 1'b1);
        bus.A = a; bus.B = b; bus.funct = f; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge i_clk); #1;
        // Garbage offered while busy must be ignored
        bus.A = $urandom; bus.B = $urandom; bus.funct = 3'(4 + $urandom_range(0, 3));
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge i_clk); #1;
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("result", bus.Out, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge i_clk); #1;
            chk("hold", {bus.out_valid, bus.in_ready, bus.Out}, {1'b1, 1'b0, exp});
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge i_clk); #1;
        bus.out_ready = 1'b0;
        chk("release", {bus.out_valid, bus.in_ready, bus.Out}, {1'b0, 1'b1, exp});
        last_out = exp;
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  rf;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.A = '0; bus.B = '0; bus.funct = 3'b100;
        #12;
        chk("reset", {bus.in_ready, bus.out_valid, bus.Out}, {1'b1, 1'b0, 32'h0});
        #10 i_rst = 1'b0;
        @(posedge i_clk); #1;

        run_op(32'd100,        32'd7,        3'b101, 0);
        run_op(32'd100,        32'd7,        3'b111, 1);
        run_op(32'hFFFF_FF9C,  32'd7,        3'b100, 0);
        run_op(32'hFFFF_FF9C,  32'd7,        3'b110, 2);
        run_op(32'h1234_5678,  32'd0,        3'b100, 0);
        run_op(32'h1234_5678,  32'd0,        3'b110, 0);
        run_op(32'h8000_0000,  32'hFFFF_FFFF, 3'b100, 0);
        run_op(32'h8000_0000,  32'hFFFF_FFFF, 3'b110, 0);
        run_op(32'hFFFF_FFFF,  32'd1,        3'b101, 10);

        for (int n = 0; n < 30; n++) begin
            ra = $urandom;
            rb = $urandom;
            rf = 3'(4 + $urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2, 3: rb = 32'($urandom_range(1, 20));
                4: rb = -32'($urandom_range(1, 20));
                default: ;
            endcase
            run_op(ra, rb, rf, $urandom_range(0, 3));
        end

        // Asynchronous reset mid-iteration
        bus.A = 32'd5000; bus.B = 32'd7; bus.funct = 3'b101; bus.in_valid = 1'b1;
        @(posedge i_clk); #1;
        bus.in_valid = 1'b0;
        repeat (14) @(posedge i_clk);
        #2 i_rst = 1'b1;
        #1 chk("rst_mid", {bus.in_ready, bus.out_valid, bus.Out}, {1'b1, 1'b0, 32'h0});
        #3 i_rst = 1'b0;
        @(posedge i_clk); #1;
        run_op(32'd9, 32'd3, 3'b101, 0);

`ifdef ITER_DIV_FLUSH_EN
        begin
            int seen;
            bus.A = 32'd1000; bus.B = 32'd3; bus.funct = 3'b101; bus.in_valid = 1'b1;
            @(posedge i_clk); #1;
            bus.in_valid = 1'b0;
            repeat (9) @(posedge i_clk);
            #1 flush = 1'b1;
            @(posedge i_clk); #1;
            flush = 1'b0;
            chk("flush_idle", {bus.in_ready, bus.out_valid, bus.Out}, {1'b1, 1'b0, last_out});
            seen = 0;
            repeat (40) begin
                @(posedge i_clk); #1;
                if (bus.out_valid) seen++;
            end
            chk("flush_no_valid", seen, 0);
            bus.A = 32'd8; bus.B = 32'd2; bus.funct = 3'b101; bus.in_valid = 1'b1; flush = 1'b1;
            @(posedge i_clk); #1;
            flush = 1'b0; bus.in_valid = 1'b0;
            @(posedge i_clk); #1;
            chk("flush_beats_accept", {bus.in_ready, bus.out_valid}, 2'b10);
            run_op(32'd8, 32'd2, 3'b101, 0);
        end
`endif

        chk("ready_valid_excl", excl_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/iter_div_unit.md
Name: iter_div_unit

Overview:
- Multi-cycle RV32M divide/remainder unit in the execute stage, alongside the single-cycle ALU.
- Takes the same A/B operands the ALU takes.
- Its result feeds the same writeback-select mux as the ALU Out, via a ready/valid handshake.
- Decode stalls the pipeline while the unit is busy.
- Restoring division, one quotient bit per cycle.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  an operation is presented on A/B/funct.
- in_ready  output  1  unit can accept an operation. High only in IDLE.
- A  input  WIDTH  dividend (rs1).
- B  input  WIDTH  divisor (rs2).
- funct  input  3  100=DIV, 101=DIVU, 110=REM, 111=REMU. Values 000-011 are not used and are never issued.
- out_valid  output  1  Out holds a completed result.
- out_ready  input  1  downstream consumes the result.
- Out  output  WIDTH  quotient or remainder.

Behaviour:
- States: IDLE, CALC, DONE.
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, Out=0, counter=0, internal remainder/quotient registers=0. An operation in progress is discarded.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1, capture funct and the operand magnitudes. Magnitude is |A| and |B| for signed ops, raw values for unsigned ops.
  - Capture the result signs: quotient negative = A[31]^B[31] (signed, B!=0); remainder negative = A[31] (signed).
  - Special cases go straight to DONE. All other cases go to CALC with counter=0.
- Special cases, no iteration, out_valid in the cycle after acceptance:
  - B==0: quotient=0xFFFFFFFF for DIV and DIVU; remainder=A for REM and REMU.
  - Signed overflow, A=0x80000000 and B=0xFFFFFFFF, DIV: quotient=0x80000000.
  - Signed overflow, REM: remainder=0.
- CALC:
  - Each edge shifts {rem,quo} left by 1 and trial-subtracts the divisor from rem, using a WIDTH+1-bit subtract.
  - If the subtract result is non-negative, keep the difference and set the quotient LSB to 1. Otherwise restore rem and set the quotient LSB to 0.
  - counter increments each edge. The edge where counter==WIDTH-1 moves to DONE.
  - Total: 32 CALC edges, so out_valid rises in the 33rd cycle after the accepting edge.
- DONE:
  - out_valid=1. Out is registered: the sign-corrected quotient (DIV/DIVU) or remainder (REM/REMU), written on the edge entering DONE.
  - Out holds stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1, go to IDLE and clear out_valid. Out retains its last value.
- Handshake rules:
  - in_valid is ignored outside IDLE.
  - There is no same-cycle accept in DONE, so back-to-back operations have one IDLE bubble.
  - in_ready and out_valid are never both 1.
- A, B and funct are sampled only on the accepting edge. Later changes have no effect.

Optional Feature:
- Macro: ITER_DIV_FLUSH_EN.
- Defined:
  - Adds input port Flush (1 bit).
  - Flush=1 on any edge forces IDLE and out_valid=0, overriding all other transitions, including acceptance in the same cycle.
  - Out is left unchanged.
  - Used on branch mispredict squash.
- Undefined: no Flush port. The unit leaves CALC or DONE only through completion or Reset.

Test Plan:
- DIVU: A=100, B=7, funct=101 -> out_valid in the 33rd cycle after accept, Out=0x0000000E. REMU with the same operands -> Out=0x00000002.
- DIV: A=0xFFFFFF9C (-100), B=7 -> Out=0xFFFFFFF2 (-14). REM with the same operands -> Out=0xFFFFFFFE (-2).
- Divide by zero: DIV A=0x12345678, B=0 -> out_valid in the cycle after accept, Out=0xFFFFFFFF. REM with the same operands -> Out=0x12345678.
- Overflow: DIV A=0x80000000, B=0xFFFFFFFF -> Out=0x80000000 after 1 cycle. REM with the same operands -> Out=0.
- Backpressure: DIVU 0xFFFFFFFF/1 with out_ready=0 for 10 cycles -> out_valid and Out=0xFFFFFFFF stable, in_ready=0 throughout. Raising out_ready -> IDLE on the next edge.
- Reset mid-CALC: assert Reset at iteration 15 -> immediately out_valid=0, in_ready=1, Out=0. A new DIVU 9/3 then completes with Out=3.
- With ITER_DIV_FLUSH_EN: pulse Flush at iteration 10 -> IDLE next edge, no out_valid.
